// File: rtl/dbg_cmd_if.sv
// Byte-stream link to the debug UART plus the system bus master port of the debug command engine.
interface dbg_cmd_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;

  modport master (
    input  rx_valid, rx_data, tx_ready, bus_rdata, bus_ack,
    output tx_valid, tx_data, bus_req, bus_we, bus_addr, bus_wdata
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, bus_rdata, bus_ack,
    input  tx_valid, tx_data, bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/dbg_cmd_engine.sv
// Debug command engine: parses "+XY<args>" frames from the UART byte stream, drives the bus
// master port and CPU halt/reset lines, and streams the response back byte by byte.
module dbg_cmd_engine #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_BURST    = 16,
  parameter int BUS_TIMEOUT  = 255,
  parameter int RX_TIMEOUT   = 100000,
  parameter int RESET_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  dbg_cmd_if.master   io,
  input  logic [31:0] cpu_pc,
  output logic        ds_cpu_halt,
  output logic        ds_cpu_reset
);
  localparam int ABYTES = ADDR_W / 8;
  localparam int DBYTES = DATA_W / 8;
  localparam int IDX_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int RX_TW  = $clog2(RX_TIMEOUT + 1);
  localparam int BUS_TW = $clog2(BUS_TIMEOUT + 1);
  localparam int RST_TW = $clog2(RESET_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, CMD1, CMD2, ARG, BUS, RSTP, SEND} state_t;
  typedef enum logic [2:0] {C_HL, C_RE, C_ST, C_PC, C_MR, C_MW, C_RS, C_BAD} cmd_t;
  typedef enum logic [1:0] {R_OK, R_NO, R_TO} resp_t;

  state_t            state, state_next;
  cmd_t              cmd, cmd_dec;
  resp_t             resp;
  logic [7:0]        cmd0;
  logic              halted;
  logic              cpu_reset_n;
  logic [3:0]        arg_cnt;
  logic [ADDR_W-1:0] addr_sh;
  logic [DATA_W-1:0] wdata_sh;
  logic [7:0]        nwords;
  logic [7:0]        word_idx;
  logic [31:0]       pc_cap;
  logic [RX_TW-1:0]  rx_tmr;
  logic [BUS_TW-1:0] bus_tmr;
  logic [RST_TW-1:0] rst_tmr;
  logic [15:0]       resp_len;
  logic [15:0]       tx_idx;
  logic [IDX_W-1:0]  word_sel;
  logic [1:0]        byte_sel;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rbuf [MAX_BURST];

  logic              rx_expired;
  logic              arg_last;
  logic              mr_legal;
  logic              bus_fire;
  logic              bus_expired;
  logic              last_word;
  logic              tx_fire;
  logic              tx_last;
  logic              rst_done;
  logic [7:0]        tx_byte;
  logic [DATA_W-1:0] rd_word;
  logic [1:0]        pc_sel;

  assign rx_expired  = (rx_tmr == RX_TW'(RX_TIMEOUT - 1));
  assign arg_last    = (arg_cnt == ((cmd == C_MW) ? 4'(ABYTES + DBYTES - 1) : 4'(ABYTES)));
  assign mr_legal    = halted && (io.rx_data != 8'd0) && (int'(io.rx_data) <= MAX_BURST);
  assign bus_fire    = req_q && io.bus_ack;
  assign bus_expired = req_q && !io.bus_ack && (bus_tmr == BUS_TW'(BUS_TIMEOUT - 1));
  assign last_word   = (word_idx == nwords - 8'd1);
  assign tx_fire     = (state == SEND) && io.tx_ready;
  assign tx_last     = (tx_idx == resp_len - 16'd1);
  assign rst_done    = (rst_tmr == RST_TW'(RESET_CYCLES - 1));

  // Command decode works on the byte arriving in CMD2 so the verdict is ready that same cycle.
  always_comb begin
    cmd_dec = C_BAD;
    case ({cmd0, io.rx_data})
      "HL":    cmd_dec = C_HL;
      "RE":    cmd_dec = C_RE;
      "ST":    cmd_dec = C_ST;
      "PC":    cmd_dec = C_PC;
      "MR":    cmd_dec = C_MR;
      "MW":    cmd_dec = C_MW;
      "RS":    cmd_dec = C_RS;
      default: cmd_dec = C_BAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (io.rx_valid && io.rx_data == 8'h2B) state_next = CMD1;
      CMD1: begin
        if (io.rx_valid)     state_next = CMD2;
        else if (rx_expired) state_next = IDLE;
      end
      CMD2: begin
        if (io.rx_valid) begin
          case (cmd_dec)
            C_MR, C_MW: state_next = ARG;
            C_RS:       state_next = RSTP;
            default:    state_next = SEND;
          endcase
        end else if (rx_expired) begin
          state_next = IDLE;
        end
      end
      ARG: begin
        if (io.rx_valid && arg_last)
          state_next = (((cmd == C_MR) ? mr_legal : halted)) ? BUS : SEND;
        else if (!io.rx_valid && rx_expired)
          state_next = IDLE;
      end
      BUS: begin
        if (bus_fire && (we_q || last_word)) state_next = SEND;
        else if (bus_expired)                state_next = SEND;
      end
      RSTP: if (rst_done) state_next = SEND;
      SEND: if (tx_fire && tx_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: argument assembly, bus sequencing, reset pulse timing and response indexing.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd         <= C_BAD;
      resp        <= R_OK;
      cmd0        <= 8'h00;
      halted      <= 1'b0;
      cpu_reset_n <= 1'b1;
      arg_cnt     <= '0;
      addr_sh     <= '0;
      wdata_sh    <= '0;
      nwords      <= '0;
      word_idx    <= '0;
      pc_cap      <= '0;
      rx_tmr      <= '0;
      bus_tmr     <= '0;
      rst_tmr     <= '0;
      resp_len    <= '0;
      tx_idx      <= '0;
      word_sel    <= '0;
      byte_sel    <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      if ((state == CMD1 || state == CMD2 || state == ARG) && !io.rx_valid)
        rx_tmr <= rx_tmr + RX_TW'(1);
      else
        rx_tmr <= '0;

      case (state)
        CMD1: if (io.rx_valid) cmd0 <= io.rx_data;
        CMD2: begin
          if (io.rx_valid) begin
            cmd      <= cmd_dec;
            arg_cnt  <= '0;
            tx_idx   <= '0;
            word_sel <= '0;
            byte_sel <= '0;
            resp     <= R_OK;
            resp_len <= 16'd2;
            case (cmd_dec)
              C_HL:  halted <= 1'b1;
              C_RE:  halted <= 1'b0;
              C_ST:  resp_len <= 16'd3;
              C_PC: begin
                resp_len <= 16'd6;
                pc_cap   <= cpu_pc;
              end
              C_RS: begin
                cpu_reset_n <= 1'b0;
                rst_tmr     <= '0;
              end
              C_BAD: resp <= R_NO;
              default: ;
            endcase
          end
        end
        ARG: begin
          if (io.rx_valid) begin
            arg_cnt <= arg_cnt + 4'd1;
            if (arg_cnt < 4'(ABYTES)) addr_sh  <= (addr_sh << 8) | ADDR_W'(io.rx_data);
            else                      wdata_sh <= (wdata_sh << 8) | DATA_W'(io.rx_data);
            if (arg_last) begin
              if (state_next == BUS) begin
                addr_q   <= addr_sh;
                we_q     <= (cmd == C_MW);
                wdata_q  <= (wdata_sh << 8) | DATA_W'(io.rx_data);
                nwords   <= io.rx_data;
                word_idx <= '0;
                bus_tmr  <= '0;
              end else begin
                resp <= R_NO;
              end
            end
          end
        end
        BUS: begin
          // Request is raised only from an idle cycle, which yields one gap cycle between burst words.
          if (!req_q) begin
            req_q   <= 1'b1;
            bus_tmr <= '0;
          end else if (io.bus_ack) begin
            req_q   <= 1'b0;
            bus_tmr <= '0;
            if (!we_q) begin
              word_idx <= word_idx + 8'd1;
              addr_q   <= addr_q + ADDR_W'(DBYTES);
              if (last_word) resp_len <= 16'(nwords) * 16'(DBYTES) + 16'd2;
            end
          end else if (bus_expired) begin
            req_q <= 1'b0;
            resp  <= R_TO;
          end else begin
            bus_tmr <= bus_tmr + BUS_TW'(1);
          end
        end
        RSTP: begin
          if (rst_done) cpu_reset_n <= 1'b1;
          else          rst_tmr <= rst_tmr + RST_TW'(1);
        end
        SEND: begin
          if (tx_fire) begin
            tx_idx <= tx_idx + 16'd1;
            if (tx_idx >= 16'd2) begin
              if (byte_sel == 2'(DBYTES - 1)) begin
                byte_sel <= '0;
                word_sel <= word_sel + IDX_W'(1);
              end else begin
                byte_sel <= byte_sel + 2'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == BUS && bus_fire && !we_q) rbuf[word_idx[IDX_W-1:0]] <= io.bus_rdata;
  end

  // Response bytes are derived from the index: two status characters, then the payload.
  always_comb begin
    tx_byte = 8'h00;
    rd_word = rbuf[word_sel];
    pc_sel  = 2'(tx_idx - 16'd2);
    if (tx_idx == 16'd0) begin
      case (resp)
        R_OK:    tx_byte = "O";
        R_NO:    tx_byte = "N";
        default: tx_byte = "T";
      endcase
    end else if (tx_idx == 16'd1) begin
      tx_byte = (resp == R_OK) ? "K" : "O";
    end else begin
      case (cmd)
        C_ST:    tx_byte = halted ? "H" : "R";
        C_PC:    tx_byte = 8'(pc_cap >> (8 * (3 - int'(pc_sel))));
        C_MR:    tx_byte = 8'(rd_word >> (8 * (DBYTES - 1 - int'(byte_sel))));
        default: tx_byte = 8'h00;
      endcase
    end
  end

  assign io.tx_valid  = (state == SEND);
  assign io.tx_data   = (state == SEND) ? tx_byte : 8'h00;
  assign io.bus_req   = req_q;
  assign io.bus_we    = we_q;
  assign io.bus_addr  = addr_q;
  assign io.bus_wdata = wdata_q;
  assign ds_cpu_halt  = halted;
  assign ds_cpu_reset = cpu_reset_n;
endmodule

// File: tb/tb_dbg_cmd_engine.sv
// Directed bench for dbg_cmd_engine: drives command frames, models the bus slave and the
// transmitter, and compares every response byte and bus transfer with hand-computed values.
module tb_dbg_cmd_engine;
  localparam int RXTO = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_pc;
  logic        ds_cpu_halt;
  logic        ds_cpu_reset;

  dbg_cmd_if #(.ADDR_W(32), .DATA_W(32)) dif ();

  dbg_cmd_engine #(
    .ADDR_W(32), .DATA_W(32), .MAX_BURST(16), .BUS_TIMEOUT(255),
    .RX_TIMEOUT(RXTO), .RESET_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .io(dif.master), .cpu_pc(cpu_pc),
    .ds_cpu_halt(ds_cpu_halt), .ds_cpu_reset(ds_cpu_reset)
  );

  always #5 clk = ~clk;

  int          n_compared = 0;
  int          n_failed = 0;
  logic [7:0]  rsp_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] ack_addr_q[$];
  logic        ack_we_q[$];
  logic [31:0] ack_wdata_q[$];
  bit          rand_ready = 1'b0;
  bit          ack_enable = 1'b1;
  int          wait_cnt = 0;
  int          req_high_cnt = 0;
  int          rst_low_cnt = 0;

  // Bus slave: acknowledges on the second cycle of each request and logs every transfer.
  always @(negedge clk) begin
    if (dif.bus_req && ack_enable) begin
      wait_cnt++;
      dif.bus_ack = (wait_cnt == 2);
      if (wait_cnt == 2) begin
        dif.bus_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
        ack_addr_q.push_back(dif.bus_addr);
        ack_we_q.push_back(dif.bus_we);
        ack_wdata_q.push_back(dif.bus_wdata);
      end
    end else begin
      dif.bus_ack = 1'b0;
      wait_cnt = 0;
    end
    if (dif.bus_req) req_high_cnt++;
    if (!ds_cpu_reset) rst_low_cnt++;
  end

  always @(negedge clk) begin
    dif.tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (dif.tx_valid && dif.tx_ready) rsp_q.push_back(dif.tx_data);
  end

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    dif.rx_valid = 1'b1;
    dif.rx_data  = b;
    @(negedge clk);
    dif.rx_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic sendCmd(input logic [7:0] c1, input logic [7:0] c2);
    applyStimulus(8'h2B);
    applyStimulus(c1);
    applyStimulus(c2);
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) applyStimulus(w[8*i +: 8]);
  endtask

  task automatic expectStr(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic expectWord(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic expectResponse(input string tag);
    int cyc = 0;
    while (rsp_q.size() < exp_q.size() && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (8) @(negedge clk);
    checkOutput({tag, "_len"}, rsp_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rsp_q.size(); i++)
      checkOutput($sformatf("%s_b%0d", tag, i), rsp_q[i], exp_q[i]);
    rsp_q.delete();
    exp_q.delete();
  endtask

  task automatic clearBusLog();
    ack_addr_q.delete();
    ack_we_q.delete();
    ack_wdata_q.delete();
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    cpu_pc = 32'h0;
    dif.rx_valid = 1'b0;
    dif.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("rst_tx_valid", dif.tx_valid, 0);
    checkOutput("rst_tx_data", dif.tx_data, 0);
    checkOutput("rst_bus_req", dif.bus_req, 0);
    checkOutput("rst_bus_we", dif.bus_we, 0);
    checkOutput("rst_bus_addr", dif.bus_addr, 0);
    checkOutput("rst_bus_wdata", dif.bus_wdata, 0);
    checkOutput("rst_halt", ds_cpu_halt, 0);
    checkOutput("rst_cpu_reset", ds_cpu_reset, 1);
    reset = 1'b0;

    applyStimulus("X"); applyStimulus("H"); applyStimulus("L");
    repeat (10) @(negedge clk);
    checkOutput("idle_ignore", rsp_q.size(), 0);
    checkOutput("idle_halt", ds_cpu_halt, 0);

    sendCmd("H", "L"); expectStr("OK"); expectResponse("hl");
    checkOutput("hl_halt", ds_cpu_halt, 1);
    sendCmd("S", "T"); expectStr("OKH"); expectResponse("st_h");
    sendCmd("H", "L"); expectStr("OK"); expectResponse("hl_again");
    sendCmd("R", "E"); expectStr("OK"); expectResponse("re");
    checkOutput("re_halt", ds_cpu_halt, 0);
    sendCmd("R", "E"); expectStr("OK"); expectResponse("re_again");
    sendCmd("S", "T"); expectStr("OKR"); expectResponse("st_r");
    sendCmd("Z", "Q"); expectStr("NO"); expectResponse("unknown");

    req_high_cnt = 0;
    sendCmd("M", "W"); sendWord(32'h0000_0010); sendWord(32'hDEAD_BEEF);
    expectStr("NO"); expectResponse("mw_run");
    sendCmd("M", "R"); sendWord(32'h0000_0100); applyStimulus(8'd1);
    expectStr("NO"); expectResponse("mr_run");
    checkOutput("run_no_req", req_high_cnt, 0);

    sendCmd("H", "L"); expectStr("OK"); expectResponse("hl2");
    clearBusLog();
    req_high_cnt = 0;
    sendCmd("M", "W"); sendWord(32'h0000_0010); sendWord(32'hDEAD_BEEF);
    expectStr("OK"); expectResponse("mw");
    checkOutput("mw_count", ack_addr_q.size(), 1);
    checkOutput("mw_addr", ack_addr_q[0], 32'h10);
    checkOutput("mw_we", ack_we_q[0], 1);
    checkOutput("mw_wdata", ack_wdata_q[0], 32'hDEAD_BEEF);
    checkOutput("mw_req_cycles", req_high_cnt, 2);

    clearBusLog();
    rand_ready = 1'b1;
    rd_q = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};
    sendCmd("M", "R"); sendWord(32'h0000_0100); applyStimulus(8'd3);
    expectStr("OK");
    expectWord(32'h1122_3344); expectWord(32'h5566_7788); expectWord(32'h99AA_BBCC);
    expectResponse("mr3");
    checkOutput("mr3_count", ack_addr_q.size(), 3);
    checkOutput("mr3_addr0", ack_addr_q[0], 32'h100);
    checkOutput("mr3_addr1", ack_addr_q[1], 32'h104);
    checkOutput("mr3_addr2", ack_addr_q[2], 32'h108);
    checkOutput("mr3_we", ack_we_q[0], 0);
    rand_ready = 1'b0;

    clearBusLog();
    rd_q = '{32'hA0A1_A2A3, 32'hB0B1_B2B3};
    sendCmd("M", "R"); sendWord(32'hFFFF_FFFC); applyStimulus(8'd2);
    expectStr("OK"); expectWord(32'hA0A1_A2A3); expectWord(32'hB0B1_B2B3);
    expectResponse("mr_wrap");
    checkOutput("wrap_addr0", ack_addr_q[0], 32'hFFFF_FFFC);
    checkOutput("wrap_addr1", ack_addr_q[1], 32'h0000_0000);

    clearBusLog();
    rd_q.delete();
    sendCmd("M", "R"); sendWord(32'h0000_0000); applyStimulus(8'd16);
    expectStr("OK");
    for (int i = 0; i < 16; i++) expectWord(32'h0);
    expectResponse("mr16");
    checkOutput("mr16_count", ack_addr_q.size(), 16);
    checkOutput("mr16_last_addr", ack_addr_q[15], 32'h3C);

    ack_enable = 1'b0;
    req_high_cnt = 0;
    sendCmd("M", "R"); sendWord(32'h0000_0020); applyStimulus(8'd2);
    expectStr("TO"); expectResponse("mr_to");
    checkOutput("to_req_cycles", req_high_cnt, 255);
    ack_enable = 1'b1;

    req_high_cnt = 0;
    sendCmd("M", "R"); sendWord(32'h0000_0020); applyStimulus(8'd0);
    expectStr("NO"); expectResponse("mr_n0");
    sendCmd("M", "R"); sendWord(32'h0000_0020); applyStimulus(8'd17);
    expectStr("NO"); expectResponse("mr_n17");
    checkOutput("illegal_no_req", req_high_cnt, 0);

    applyStimulus(8'h2B); applyStimulus("M");
    repeat (RXTO + 10) @(negedge clk);
    cpu_pc = 32'h0040_0010;
    sendCmd("P", "C");
    expectStr("OK"); expectWord(32'h0040_0010); expectResponse("pc_after_to");

    applyStimulus(8'h2B);
    repeat (RXTO - 50) @(negedge clk);
    applyStimulus("S");
    repeat (RXTO - 50) @(negedge clk);
    applyStimulus("T");
    expectStr("OKH"); expectResponse("st_slow");

    rst_low_cnt = 0;
    sendCmd("R", "S"); expectStr("OK"); expectResponse("rs");
    checkOutput("rs_low_cycles", rst_low_cnt, 16);
    checkOutput("rs_halt_kept", ds_cpu_halt, 1);
    checkOutput("rs_reset_high", ds_cpu_reset, 1);

    rd_q = '{32'h1, 32'h2, 32'h3};
    sendCmd("M", "R"); sendWord(32'h0000_0200); applyStimulus(8'd3);
    cyc = 0;
    while (!dif.bus_req && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("abort_req_seen", dif.bus_req, 1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_bus_req", dif.bus_req, 0);
    checkOutput("abort_tx_valid", dif.tx_valid, 0);
    checkOutput("abort_halt", ds_cpu_halt, 0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("abort_no_resp", rsp_q.size(), 0);
    rd_q.delete();
    sendCmd("S", "T"); expectStr("OKR"); expectResponse("st_after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end
endmodule
